// File: rtl/legv8_inst_encoder.sv
// LEGv8 instruction encoder and sequential program loader.
// Packs symbolic instructions into machine words and writes them to imem.
module legv8_inst_encoder #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                DEPTH     = 256,
   localparam int               CW        = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        op,
   input  logic [4:0]        rd,
   input  logic [4:0]        rn,
   input  logic [4:0]        rm,
   input  logic [25:0]       imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              err_valid,
   output logic [1:0]        err_code,
   output logic              done,
   output logic [CW-1:0]     word_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [3:0] OP_LDUR = 4'd0;
   localparam logic [3:0] OP_STUR = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_ADDI = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_AND  = 4'd5;
   localparam logic [3:0] OP_ORR  = 4'd6;
   localparam logic [3:0] OP_CBZ  = 4'd7;
   localparam logic [3:0] OP_CBNZ = 4'd8;
   localparam logic [3:0] OP_B    = 4'd9;
   localparam logic [3:0] OP_HALT = 4'd10;

   localparam logic [1:0] E_NONE  = 2'b00;
   localparam logic [1:0] E_OP    = 2'b01;
   localparam logic [1:0] E_RANGE = 2'b10;
   localparam logic [1:0] E_FULL  = 2'b11;

   localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH-1);
   localparam logic [CW-1:0] ALL_SLOTS = CW'(DEPTH);

   logic [1:0]  state;
   logic        halt_pend;
   logic        accept;
   logic [31:0] enc_word;
   logic        bad_op;
   logic        bad_range;
   logic        is_halt;
   logic        full;
   logic        d_ok;
   logic        cb_ok;
   logic        addi_ok;
   logic [1:0]  err_sel;

   assign in_ready = (state == S_IDLE) && !restart && !rst;
   assign accept   = in_valid && in_ready;

   // Sign-extension checks: upper bits must all match the field's sign bit
   assign d_ok    = (&imm[25:8])  || !(|imm[25:8]);
   assign cb_ok   = (&imm[25:18]) || !(|imm[25:18]);
   assign addi_ok = !(|imm[25:12]);

   always_comb begin
      enc_word  = '0;
      bad_op    = 1'b0;
      bad_range = 1'b0;
      is_halt   = 1'b0;
      unique case (op)
         OP_LDUR: begin
            enc_word  = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
            bad_range = !d_ok;
         end
         OP_STUR: begin
            enc_word  = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
            bad_range = !d_ok;
         end
         OP_ADD:  enc_word = {11'b10001011000, rm, 6'b000000, rn, rd};
         OP_SUB:  enc_word = {11'b11001011000, rm, 6'b000000, rn, rd};
         OP_AND:  enc_word = {11'b10001010000, rm, 6'b000000, rn, rd};
         OP_ORR:  enc_word = {11'b10101010000, rm, 6'b000000, rn, rd};
         OP_ADDI: begin
            enc_word  = {10'b1001000100, imm[11:0], rn, rd};
            bad_range = !addi_ok;
         end
         OP_CBZ: begin
            enc_word  = {8'b10110100, imm[18:0], rd};
            bad_range = !cb_ok;
         end
         OP_CBNZ: begin
            enc_word  = {8'b10110101, imm[18:0], rd};
            bad_range = !cb_ok;
         end
         OP_B:    enc_word = {6'b000101, imm[25:0]};
         OP_HALT: begin
            enc_word = 32'hFFFF_FFFF;
            is_halt  = 1'b1;
         end
         default: bad_op = 1'b1;
      endcase
   end

   // The final slot is kept free so a HALT can always terminate the program
   assign full = is_halt ? (word_count >= ALL_SLOTS)
                         : (word_count >= LAST_SLOT);

   always_comb begin
      err_sel = E_NONE;
      if (bad_op)
         err_sel = E_OP;
      else if (full)
         err_sel = E_FULL;
      else if (bad_range)
         err_sel = E_RANGE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         halt_pend  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= BASE_ADDR;
         mem_wdata  <= '0;
         err_valid  <= 1'b0;
         err_code   <= E_NONE;
         done       <= 1'b0;
         word_count <= '0;
      end else begin
         mem_we    <= 1'b0;
         err_valid <= 1'b0;
         unique case (state)
            S_WRITE: begin
               if (restart) begin
                  mem_addr   <= BASE_ADDR;
                  word_count <= '0;
                  err_code   <= E_NONE;
                  done       <= 1'b0;
                  state      <= S_IDLE;
               end else begin
                  mem_addr   <= mem_addr + ADDR_W'(4);
                  word_count <= word_count + CW'(1);
                  done       <= halt_pend;
                  state      <= halt_pend ? S_DONE : S_IDLE;
               end
            end
            S_IDLE, S_DONE: begin
               if (restart) begin
                  mem_addr   <= BASE_ADDR;
                  word_count <= '0;
                  err_code   <= E_NONE;
                  done       <= 1'b0;
                  state      <= S_IDLE;
               end else if (accept) begin
                  if (err_sel != E_NONE) begin
                     err_valid <= 1'b1;
                     err_code  <= err_sel;
                  end else begin
                     mem_we    <= 1'b1;
                     mem_wdata <= enc_word;
                     halt_pend <= is_halt;
                     state     <= S_WRITE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/legv8_inst_encoder.md
Name: legv8_inst_encoder

Overview:
- Encoder counterpart to the CPU control decoder. Accepts symbolic LEGv8 instructions (operation select plus register/immediate fields) over a valid/ready handshake.
- Packs each instruction into the 32-bit machine word the decoder expects and writes it sequentially into instruction memory.
- Serves as the testbench/boot-time program loader for the CPU. Loading stops at HALT.

Parameters:
- ADDR_W, 32, width of the memory byte address.
- BASE_ADDR, 0, byte address of the first instruction written.
- DEPTH, 256, maximum number of words loadable before "full".

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- restart  in  1  leave DONE, clear address/count; synchronous.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept this cycle.
- op  in  4  0 LDUR, 1 STUR, 2 ADD, 3 ADDI, 4 SUB, 5 AND, 6 ORR, 7 CBZ, 8 CBNZ, 9 B, 10 HALT; 11-15 invalid.
- rd  in  5  Rd (R/I-format) or Rt (D/CB-format).
- rn  in  5  Rn.
- rm  in  5  Rm (R-format only).
- imm  in  26  immediate, two's complement except ADDI (unsigned).
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_W  byte address of write.
- mem_wdata  out  32  encoded instruction.
- err_valid  out  1  one-cycle pulse: accepted instruction rejected.
- err_code  out  2  01 bad op, 10 immediate out of range, 11 memory full; held until next error.
- done  out  1  HALT written; load complete.
- word_count  out  $clog2(DEPTH+1)  words written so far.

Behaviour:
- Reset: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, err_valid=0, err_code=00, done=0, word_count=0. State is IDLE.
- All outputs are registered except in_ready, which equals (state==IDLE && !restart && !rst).
- FSM states: IDLE, WRITE, DONE.
  - IDLE: a handshake (in_valid && in_ready) is accepted at edge k.
    - If valid: next state WRITE. mem_we=1 with the word and current address in cycle k+1.
    - If rejected: stay IDLE and pulse err_valid in cycle k+1. No write, address and count unchanged.
  - WRITE: lasts exactly one cycle. mem_addr advances by 4 and word_count by 1 after it.
    - Next state is DONE if the op was HALT, else IDLE.
    - Throughput is therefore one instruction per 2 cycles.
  - DONE: done=1 and in_ready=0. Any in_valid is ignored. Only restart or rst exits.
- Restart: in IDLE or DONE, mem_addr=BASE_ADDR, word_count=0, done=0, err_code=00, next state IDLE. In WRITE, the write completes first and restart is applied the following cycle. Restart wins over a simultaneous in_valid, which is not accepted.
- Encodings:
  - LDUR/STUR: {11111000010 / 11111000000, imm[8:0], 00, rn, rd}.
  - ADD/SUB/AND/ORR: {10001011000 / 11001011000 / 10001010000 / 10101010000, rm, 000000, rn, rd}.
  - ADDI: {1001000100, imm[11:0], rn, rd}.
  - CBZ/CBNZ: {10110100 / 10110101, imm[18:0], rd}.
  - B: {000101, imm[25:0]}.
  - HALT: 32'hFFFFFFFF; fields ignored.
- Range checks (fail gives err_code 10):
  - D-format: imm must be a 9-bit signed value, i.e. imm[25:8] all equal.
  - CB-format: imm must be a 19-bit signed value, i.e. imm[25:18] all equal.
  - ADDI: imm[25:12]==0.
  - R-format, B and HALT: no check. Unused fields are ignored.
- Error priority: bad op, then full, then range.
- Full: a non-HALT op when word_count==DEPTH-1 gives err_code 11. The last slot is reserved for HALT. HALT is always written if word_count<DEPTH.
- rst mid-WRITE: mem_we=0 on the next cycle and all outputs return to reset values.

Test Plan:
- Reset, then ADD rd=3, rn=1, rm=2 -> in cycle k+1 mem_we=1, mem_addr=0, mem_wdata=0x8B020023. Then word_count=1 and mem_addr=4.
- Back-to-back LDUR rd=5, rn=2, imm=8 then STUR rd=5, rn=2, imm=-256 -> words 0xF8408045 then 0xF8100045 at addresses 0 and 4. in_ready is low during each WRITE cycle.
- ADDI rd=1, rn=0, imm=4095 -> 0x913FFC01. ADDI with imm=4096 -> err_valid pulse, err_code=10, no write, address unchanged.
- CBZ rd=7, imm=-2 -> 0xB4FFFFC7. B imm=3 -> 0x14000003. CBNZ with imm=0x40000 -> err_code=10. op=12 -> err_code=01.
- HALT -> 0xFFFFFFFF written, then done=1 and in_ready=0, and in_valid is ignored for 5 cycles. restart together with in_valid -> in_ready=0 that cycle, then mem_addr=0, word_count=0, done=0.
- DEPTH=2: ADD accepted; second ADD -> err_code=11; HALT -> written, word_count=2, done=1. Assert rst during a WRITE cycle -> mem_we=0 on the following cycle and all outputs at reset values.
